// File: rtl/cheriot_dv_memcmd_tracker.sv
// Multi-channel OBI memory-port monitor: pairs each response with its granted
// request via a per-channel in-order FIFO, then streams completed mem-command
// records through a round-robin arbiter with stall-stable selection.
module cheriot_dv_memcmd_tracker #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DW          = 33,
  parameter logic [31:0] DRAM_START  = 32'h8000_0000,
  parameter logic [31:0] TSMAP_START = 32'h8300_0000,
  parameter logic [31:0] TSMAP_SIZE  = 32'h0000_4000,
  localparam int unsigned CHW        = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned OW         = $clog2(DEPTH + 1),
  localparam int unsigned CMDW       = 45 + 2 * DW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NCH-1:0]      req_i,
  input  logic [NCH-1:0]      gnt_i,
  input  logic [NCH-1:0]      we_i,
  input  logic [NCH-1:0]      is_cap_i,
  input  logic [NCH*4-1:0]    be_i,
  input  logic [NCH*32-1:0]   addr_i,
  input  logic [NCH*DW-1:0]   wdata_i,
  input  logic [NCH-1:0]      rvalid_i,
  input  logic [NCH*DW-1:0]   rdata_i,
  input  logic [NCH-1:0]      err_i,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output logic [CMDW-1:0]     cmd_o,
  output logic [CHW-1:0]      cmd_ch_o,
  output logic [NCH*OW-1:0]   outstanding_o,
  output logic [NCH-1:0]      overflow_o,
  output logic [NCH-1:0]      unexpected_o,
  output logic [NCH-1:0]      lost_o
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned PTRW = PW + 1;

  typedef struct packed {
    logic [7:0]    flag;
    logic          is_cap;
    logic          we;
    logic [3:0]    be;
    logic [29:0]   addr;
    logic [DW-1:0] wdata;
  } req_ent_t;

  typedef struct packed {
    req_ent_t      req;
    logic [DW-1:0] rdata;
    logic          err;
  } mem_cmd_t;

  logic [PTRW-1:0] wp_q [NCH];
  logic [PTRW-1:0] rp_q [NCH];
  req_ent_t        fifo_q [NCH][DEPTH];
  mem_cmd_t        slot_q [NCH];
  logic [NCH-1:0]  slot_v_q;
  logic [CHW-1:0]  rr_q;
  logic [CHW-1:0]  lock_ch_q;
  logic            lock_q;

  req_ent_t        push_ent [NCH];
  mem_cmd_t        done_cmd [NCH];
  logic [NCH-1:0]  full, push_ok, pop, clr, load;
  logic [NCH-1:0]  ovf_set, unx_set, lost_set;
  logic [CHW-1:0]  rr_idx, rr_win, win;
  logic            rr_found, accept;

  // Region flags; TS-map bound is evaluated in 33 bits so it cannot wrap.
  function automatic logic [7:0] region_flag(input logic [31:0] a, input logic cap);
    logic [32:0] a33, ts_lo, ts_hi;
    a33   = {1'b0, a};
    ts_lo = {1'b0, TSMAP_START};
    ts_hi = ts_lo + {1'b0, TSMAP_SIZE};
    region_flag    = '0;
    region_flag[0] = (a >= DRAM_START) && (a < TSMAP_START);
    region_flag[1] = (a33 >= ts_lo) && (a33 < ts_hi);
    region_flag[2] = cap & a[2];
  endfunction

  // Round-robin pick, overridden by the latched winner while the consumer stalls.
  always_comb begin
    rr_idx   = '0;
    rr_win   = '0;
    rr_found = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      rr_idx = CHW'((32'(rr_q) + i) % NCH);
      if (!rr_found && slot_v_q[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
    win         = lock_q ? lock_ch_q : rr_win;
    cmd_valid_o = |slot_v_q;
    accept      = cmd_valid_o && cmd_ready_i;
    cmd_ch_o    = cmd_valid_o ? win : '0;
    cmd_o       = cmd_valid_o ? slot_q[win] : '0;
  end

  // Per-channel push/pop/slot decisions and error detection.
  always_comb begin
    outstanding_o = '0;
    full     = '0;
    push_ok  = '0;
    pop      = '0;
    clr      = '0;
    load     = '0;
    ovf_set  = '0;
    unx_set  = '0;
    lost_set = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      push_ent[c] = '0;
      done_cmd[c] = '0;
    end
    for (int unsigned c = 0; c < NCH; c++) begin
      outstanding_o[c*OW +: OW] = OW'(wp_q[c] - rp_q[c]);
      full[c]     = (wp_q[c] - rp_q[c]) == PTRW'(DEPTH);
      pop[c]      = rvalid_i[c] && (wp_q[c] != rp_q[c]);
      unx_set[c]  = rvalid_i[c] && (wp_q[c] == rp_q[c]);
      push_ok[c]  = req_i[c] && gnt_i[c] && (!full[c] || pop[c]);
      ovf_set[c]  = req_i[c] && gnt_i[c] && full[c] && !pop[c];
      clr[c]      = accept && (win == CHW'(c));
      load[c]     = pop[c] && (!slot_v_q[c] || clr[c]);
      lost_set[c] = pop[c] && slot_v_q[c] && !clr[c];
      push_ent[c].flag   = region_flag(addr_i[c*32 +: 32], is_cap_i[c]);
      push_ent[c].is_cap = is_cap_i[c];
      push_ent[c].we     = we_i[c];
      push_ent[c].be     = be_i[c*4 +: 4];
      push_ent[c].addr   = addr_i[c*32+2 +: 30];
      push_ent[c].wdata  = wdata_i[c*DW +: DW];
      done_cmd[c].req    = fifo_q[c][rp_q[c][PW-1:0]];
      done_cmd[c].rdata  = rdata_i[c*DW +: DW];
      done_cmd[c].err    = err_i[c];
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (push_ok[c]) fifo_q[c][wp_q[c][PW-1:0]] <= push_ent[c];
    end
  end

  // Pointers, output slots, arbiter state and sticky error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        wp_q[c]   <= '0;
        rp_q[c]   <= '0;
        slot_q[c] <= '0;
      end
      slot_v_q     <= '0;
      rr_q         <= CHW'(NCH - 1);
      lock_q       <= 1'b0;
      lock_ch_q    <= '0;
      overflow_o   <= '0;
      unexpected_o <= '0;
      lost_o       <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (push_ok[c]) wp_q[c]   <= wp_q[c] + PTRW'(1);
        if (pop[c])     rp_q[c]   <= rp_q[c] + PTRW'(1);
        if (load[c])    slot_q[c] <= done_cmd[c];
      end
      slot_v_q     <= (slot_v_q & ~clr) | load;
      if (accept) rr_q <= win;
      lock_q       <= cmd_valid_o && !cmd_ready_i;
      lock_ch_q    <= win;
      overflow_o   <= overflow_o | ovf_set;
      unexpected_o <= unexpected_o | unx_set;
      lost_o       <= lost_o | lost_set;
    end
  end

endmodule

// File: doc/cheriot_dv_memcmd_tracker.md
Name: cheriot_dv_memcmd_tracker

Overview:
- Parametrised bus monitor for the CHERIoT DV testbench. It observes NCH OBI-style memory ports (req/gnt/rvalid with 33-bit tagged data) and keeps a per-channel in-order FIFO of granted requests.
- Each response is paired with its request. The result is emitted as a completed mem-command record (the existing mem_cmd_t layout) on a single valid/ready stream, arbitrated round-robin across channels.
- It replaces per-testbench ad-hoc monitors. It adds multi-channel support, configurable depth, address-region flagging, and sticky protocol-error reporting.

Parameters:
- NCH, 2, number of monitored memory channels (1..8).
- DEPTH, 4, outstanding-request FIFO depth per channel (power of 2, >=2).
- DW, 33, bus data width including tag bit.
- DRAM_START, 32'h8000_0000, base of DRAM region.
- TSMAP_START, 32'h8300_0000, base of tag/TS-map region; also the top (exclusive) of the DRAM region.
- TSMAP_SIZE, 32'h0000_4000, size in bytes of the TS-map region.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NCH  per-channel request.
- gnt_i  in  NCH  per-channel grant.
- we_i  in  NCH  write enable.
- is_cap_i  in  NCH  access is part of a capability transfer.
- be_i  in  NCH*4  byte enables.
- addr_i  in  NCH*32  byte address.
- wdata_i  in  NCH*DW  write data.
- rvalid_i  in  NCH  response valid.
- rdata_i  in  NCH*DW  read data.
- err_i  in  NCH  response error.
- cmd_valid_o  out  1  completed record available.
- cmd_ready_i  in  1  consumer accepts record.
- cmd_o  out  111  packed record {flag[7:0], is_cap, we, be[3:0], addr32[29:0], wdata[32:0], rdata[32:0], err}.
- cmd_ch_o  out  $clog2(NCH) (min 1)  channel index of cmd_o.
- outstanding_o  out  NCH*$clog2(DEPTH+1)  per-channel FIFO occupancy.
- overflow_o  out  NCH  sticky: grant seen with FIFO full and no same-cycle pop.
- unexpected_o  out  NCH  sticky: rvalid seen with FIFO empty.
- lost_o  out  NCH  sticky: completion dropped because the output slot was still occupied.

Behaviour:
- Reset: all FIFOs empty, all output slots empty, outstanding_o=0, all sticky flags=0, cmd_valid_o=0, cmd_o=0, RR pointer=NCH-1 (so channel 0 has first priority).
- Push: req_i&gnt_i pushes {is_cap, we, be, addr[31:2], wdata, flag} into that channel's FIFO at the clock edge.
- Flag computation at push:
  - flag[0] = DRAM_START <= addr < TSMAP_START.
  - flag[1] = TSMAP_START <= addr < TSMAP_START+TSMAP_SIZE, computed in 33 bits so there is no wrap.
  - flag[2] = is_cap & addr[2], marking the cap high word.
  - flag[7:3] = 0.
- Pop: rvalid_i pops the FIFO head and combines it with rdata_i/err_i into that channel's 1-entry output slot at the same edge.
  - The rdata field is captured for writes too.
  - wdata is captured for reads too, as driven.
- Latency: response at edge t gives a slot valid after t; cmd_valid_o can assert in the cycle following that edge.
- Full FIFO with simultaneous push and pop: both are accepted; occupancy is unchanged.
- Full FIFO with push and no pop: the push is dropped and overflow_o[ch] is set.
- Empty FIFO with rvalid: no pop occurs, even if a push happens in the same cycle (no bypass). unexpected_o[ch] is set and the push is still accepted.
- Output slot occupied and not accepted this cycle, with a new completion: the new completion is dropped and lost_o[ch] is set.
  - If the slot is accepted in the same cycle, it reloads and no loss is flagged.
- Arbitration: round-robin among valid slots, searching upward from RR pointer+1 modulo NCH.
  - cmd_o and cmd_ch_o are combinational muxes of the winning slot.
  - On cmd_valid_o&cmd_ready_i the winner's slot clears and the RR pointer is set to the winner.
  - While the consumer stalls, the selection holds stable: the winner is latched until accepted, and cmd_o/cmd_ch_o must not change while cmd_valid_o=1 and cmd_ready_i=0.
- FIFO pointers wrap modulo DEPTH with an extra wrap bit. outstanding_o equals write pointer minus read pointer.
- Sticky flags clear only on reset.
- Reset asserted mid-operation discards all FIFO and slot contents immediately.

Test Plan:
- Ch0: read grant at addr 32'h8000_0010, rvalid 3 cycles later with rdata 33'h1_DEAD_BEEF, cmd_ready_i=1.
  - Required: one record with addr32=30'h2000_0004, flag=8'h01, rdata=33'h1_DEAD_BEEF, cmd_ch_o=0, one cycle after rvalid.
- Ch1: 4 back-to-back grants to 32'h8300_0000..0C, then a 5th grant with no pop.
  - Required: outstanding_o[1]=4 and overflow_o[1]=1; the 4 records come out in order with flag=8'h02.
  - Then grant and rvalid in the same cycle at full: occupancy stays 4, overflow_o[1] does not re-trigger.
- Both channels complete in the same cycle, repeated 4 times, cmd_ready_i=1.
  - Required: cmd_ch_o sequence 0,1,0,1,... with no lost_o.
- cmd_ready_i=0 for 3 cycles while ch0 completes twice.
  - Required: lost_o[0]=1; the first record is held stable on cmd_o throughout.
- rvalid on ch0 with empty FIFO.
  - Required: unexpected_o[0]=1, no record emitted.
- Cap write of 2 beats at 32'h8000_0100 and 32'h8000_0104 with is_cap=1.
  - Required: flag values 8'h01 and 8'h05.
- rst_ni pulsed low asynchronously mid-burst.
  - Required: all outputs 0 immediately, and no records afterwards until new grants.
